// File: rtl/aes_io_pkg.sv
// Shared widths, sequencer state encoding and debug view for the AES host I/O sequencer.
package aes_io_pkg;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;
    localparam int BLOCK_W   = WORD_W * NUM_WORDS;

    typedef enum logic [2:0] {
        LOAD_KEY,
        LOAD_MSG,
        REQUEST,
        DRAIN,
        RECYCLE
    } seq_state_t;

    typedef struct packed {
        seq_state_t          state;
        logic [1:0]          word_cnt;
        logic [WORD_W-1:0]   key_top;
        logic [WORD_W-1:0]   msg_top;
        logic [BLOCK_W-1:0]  rd_buf;
    } seq_dbg_t;
endpackage

// File: rtl/aes_word_shifter.sv
// 128-bit block register: parallel load, 32-bit shift-in at the LSB end, shift-out from the top.
module aes_word_shifter
    import aes_io_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [BLOCK_W-1:0] din,
    input  logic               shift_in,
    input  logic [WORD_W-1:0]  win,
    input  logic               shift_out,
    output logic [BLOCK_W-1:0] q,
    output logic [WORD_W-1:0]  wout
);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift_in) begin
            q <= {q[BLOCK_W-WORD_W-1:0], win};
        end else if (shift_out) begin
            q <= {q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
    end

    assign wout = q[BLOCK_W-1 -: WORD_W];
endmodule

// File: rtl/aes_io_sequencer.sv
// Host-side AES decrypt sequencer: gathers key and ciphertext words, requests a decrypt,
// streams the plaintext back and then resets the AES controller out of its READY state.
module aes_io_sequencer
    import aes_io_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_valid,
    input  logic [WORD_W-1:0]  wr_data,
    output logic               wr_ready,
    output logic               rd_valid,
    output logic [WORD_W-1:0]  rd_data,
    input  logic               rd_ready,
    output logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] msg_en,
    output logic               io_ready,
    input  logic               aes_ready,
    input  logic [BLOCK_W-1:0] msg_de,
    output logic               aes_rst_n,
    output logic               timeout,
    output seq_dbg_t           dbg
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [1:0]         word_cnt;
    logic [TW-1:0]      tcnt;
    logic               timeout_q;
    logic               wr_fire, rd_fire, capture, expire;
    logic [WORD_W-1:0]  key_top, msg_top;
    logic [BLOCK_W-1:0] rd_buf;

    // Both ports move a word only on a cycle where valid && ready; the producer holds
    // data and valid steady until that cycle, and ready never depends on valid.
    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_valid && rd_ready;
    assign capture = (state_q == REQUEST) && aes_ready;
    assign expire  = (state_q == REQUEST) && !aes_ready && (tcnt == T_MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= LOAD_KEY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        io_ready = 1'b0;
        rd_valid = 1'b0;
        unique case (state_q)
            LOAD_KEY: begin
                wr_ready = 1'b1;
                if (wr_valid && word_cnt == 2'd3) state_d = LOAD_MSG;
            end
            LOAD_MSG: begin
                wr_ready = 1'b1;
                if (wr_valid && word_cnt == 2'd3) state_d = REQUEST;
            end
            REQUEST: begin
                io_ready = 1'b1;
                if (aes_ready)            state_d = DRAIN;
                else if (tcnt == T_MAX)   state_d = RECYCLE;
            end
            DRAIN: begin
                rd_valid = 1'b1;
                if (rd_ready && word_cnt == 2'd3) state_d = RECYCLE;
            end
            RECYCLE: state_d = LOAD_KEY;
            default: state_d = LOAD_KEY;
        endcase
    end

    // One counter serves both the write and read phases; it wraps to 0 on the 4th transfer.
    always_ff @(posedge clk) begin
        if (!reset_n)               word_cnt <= 2'd0;
        else if (wr_fire || rd_fire) word_cnt <= word_cnt + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || state_q != REQUEST) tcnt <= '0;
        else                                tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)    timeout_q <= 1'b0;
        else if (capture) timeout_q <= 1'b0;
        else if (expire)  timeout_q <= 1'b1;
    end

    aes_word_shifter u_key (
        .clk(clk), .reset_n(reset_n),
        .load(1'b0), .din('0),
        .shift_in(wr_fire && state_q == LOAD_KEY), .win(wr_data),
        .shift_out(1'b0), .q(key), .wout(key_top)
    );

    aes_word_shifter u_msg (
        .clk(clk), .reset_n(reset_n),
        .load(1'b0), .din('0),
        .shift_in(wr_fire && state_q == LOAD_MSG), .win(wr_data),
        .shift_out(1'b0), .q(msg_en), .wout(msg_top)
    );

    aes_word_shifter u_rd (
        .clk(clk), .reset_n(reset_n),
        .load(capture), .din(msg_de),
        .shift_in(1'b0), .win('0),
        .shift_out(rd_fire), .q(rd_buf), .wout(rd_data)
    );

    assign aes_rst_n = reset_n && (state_q != RECYCLE);
    assign timeout   = timeout_q;

    assign dbg.state    = state_q;
    assign dbg.word_cnt = word_cnt;
    assign dbg.key_top  = key_top;
    assign dbg.msg_top  = msg_top;
    assign dbg.rd_buf   = rd_buf;
endmodule

// File: tb/tb_aes_io_sequencer.sv
// Directed bench for aes_io_sequencer with a behavioural aes_controller model.
module tb_aes_io_sequencer;
    import aes_io_pkg::*;

    localparam int TO = 16;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] P3 = 128'h0f0e0d0c0b0a09080706050403020100;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic [31:0]  wr_data = '0;
    logic         wr_ready;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic         rd_ready = 1'b0;
    logic [127:0] key, msg_en;
    logic         io_ready;
    logic         aes_ready;
    logic [127:0] msg_de;
    logic         aes_rst_n;
    logic         timeout;
    seq_dbg_t     dbg;

    logic         model_ready = 1'b0;
    logic [127:0] model_de = '0;
    logic [127:0] model_pt = '0;
    logic         model_en = 1'b1;
    logic         pulse_ready = 1'b0;
    int           model_delay = 0;
    int           dcnt = 0;
    int           wr_acc = 0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    aes_io_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .key(key), .msg_en(msg_en), .io_ready(io_ready),
        .aes_ready(aes_ready), .msg_de(msg_de),
        .aes_rst_n(aes_rst_n), .timeout(timeout), .dbg(dbg)
    );

    // aes_controller model: READY after model_delay cycles of io_ready, held until reset
    always @(posedge clk) begin
        if (!aes_rst_n) begin
            model_ready <= 1'b0;
            dcnt        <= 0;
        end else if (io_ready && model_en && !model_ready) begin
            if (dcnt >= model_delay) begin
                model_ready <= 1'b1;
                model_de    <= model_pt;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end
    assign aes_ready = model_ready | pulse_ready;
    assign msg_de    = model_de;

    always @(posedge clk) if (reset_n && wr_valid && wr_ready) wr_acc <= wr_acc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_state", dbg.state, LOAD_KEY);
        check_eq("rst_cnt", dbg.word_cnt, 2'd0);
        check_eq("rst_wr_ready", wr_ready, 1'b1);
        check_eq("rst_rd_valid", rd_valid, 1'b0);
        check_eq("rst_io_ready", io_ready, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        check_eq("rst_aes_rst_n", aes_rst_n, 1'b0);
        check_eq("rst_key", key, '0);
        check_eq("rst_msg_en", msg_en, '0);
        check_eq("rst_rd_buf", dbg.rd_buf, '0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release_aes_rst_n", aes_rst_n, 1'b1);
    endtask

    // driver: words back to back, from the negedge
    task automatic write_job(input logic [127:0] k, input logic [127:0] c, input int nwords,
                             input bit hold_valid, input int pulse_at);
        logic [255:0] words;
        words = {k, c};
        for (int i = 0; i < nwords; i++) begin
            wr_valid    = 1'b1;
            wr_data     = words[255 - 32*i -: 32];
            pulse_ready = (i == pulse_at);
            check_eq("wr_ready_load", wr_ready, 1'b1);
            @(negedge clk);
        end
        pulse_ready = 1'b0;
        wr_valid    = hold_valid;
        if (nwords == 8) begin
            check_eq("key", key, k);
            check_eq("msg_en", msg_en, c);
            check_eq("req_state", dbg.state, REQUEST);
            check_eq("req_io_ready", io_ready, 1'b1);
            check_eq("req_wr_ready", wr_ready, 1'b0);
        end
    endtask

    task automatic wait_aes(input logic [127:0] pt);
        int n;
        bit io_low;
        n = 0; io_low = 0;
        while (!aes_ready && n < 200) begin
            if (!io_ready || wr_ready) io_low = 1;
            @(negedge clk);
            n++;
        end
        check_eq("aes_ready_wait", n < 200, 1'b1);
        check_eq("io_ready_held", io_low, 1'b0);
        check_eq("io_ready_at_ready", io_ready, 1'b1);
        @(negedge clk);
        check_eq("drain_state", dbg.state, DRAIN);
        check_eq("drain_io_ready", io_ready, 1'b0);
        check_eq("capture", dbg.rd_buf, pt);
        check_eq("timeout_cleared", timeout, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(pt[127 - 32*i -: 32]);
    endtask

    // scoreboard: each accepted read pops the expected word; stalls must hold it
    task automatic drain_job(input int stall_mode);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 64) begin
            rd_ready = (stall_mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
            check_eq("rd_valid", rd_valid, 1'b1);
            check_eq("rd_wr_ready", wr_ready, 1'b0);
            check_eq("rd_data", rd_data, exp_q[0]);
            if (rd_ready) void'(exp_q.pop_front());
            @(negedge clk);
            n++;
        end
        rd_ready = 1'b0;
        check_eq("drain_done", exp_q.size(), 0);
        if (stall_mode == 0) check_eq("drain_cycles", n, 4);
    endtask

    task automatic check_recycle(input logic exp_to);
        check_eq("rec_state", dbg.state, RECYCLE);
        check_eq("rec_aes_rst_n", aes_rst_n, 1'b0);
        check_eq("rec_wr_ready", wr_ready, 1'b0);
        check_eq("rec_rd_valid", rd_valid, 1'b0);
        check_eq("rec_io_ready", io_ready, 1'b0);
        wr_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rec_state", dbg.state, LOAD_KEY);
        check_eq("post_rec_aes_rst_n", aes_rst_n, 1'b1);
        check_eq("post_rec_wr_ready", wr_ready, 1'b1);
        check_eq("post_rec_cnt", dbg.word_cnt, 2'd0);
        check_eq("post_rec_timeout", timeout, exp_to);
    endtask

    initial begin
        int n;
        int acc0;
        do_reset();

        // basic job, then plaintext streamed with rd_ready held high
        model_delay = 10; model_pt = P1;
        write_job(K1, C1, 8, 1'b0, -1);
        rd_ready = 1'b1;
        wait_aes(P1);
        drain_job(0);
        check_recycle(1'b0);

        // same job with stalled reads
        model_delay = 3;
        write_job(K1, C1, 8, 1'b0, -1);
        wait_aes(P1);
        drain_job(1);
        check_recycle(1'b0);

        // controller never answers
        model_en = 1'b0;
        write_job(K2, C2, 8, 1'b0, -1);
        n = 0;
        while (io_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_cycles", n, TO);
        check_eq("timeout_set", timeout, 1'b1);
        check_eq("timeout_no_capture", dbg.rd_buf, '0);
        check_recycle(1'b1);
        model_en = 1'b1; model_delay = 2; model_pt = P2;
        write_job(K2, C2, 8, 1'b0, -1);
        check_eq("timeout_sticky", timeout, 1'b1);
        wait_aes(P2);
        drain_job(0);
        check_recycle(1'b0);

        // reset in the middle of loading
        write_job(K1, C1, 6, 1'b0, -1);
        check_eq("partial_state", dbg.state, LOAD_MSG);
        check_eq("partial_cnt", dbg.word_cnt, 2'd2);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort_wr_ready", wr_ready, 1'b1);
        check_eq("abort_io_ready", io_ready, 1'b0);
        check_eq("abort_key", key, '0);
        check_eq("abort_msg_en", msg_en, '0);
        check_eq("abort_cnt", dbg.word_cnt, 2'd0);
        check_eq("abort_state", dbg.state, LOAD_KEY);
        reset_n = 1'b1;
        @(negedge clk);
        write_job(K2, C2, 8, 1'b0, -1);
        wait_aes(P2);
        drain_job(1);
        check_recycle(1'b0);

        // wr_valid held through REQUEST/DRAIN, stray aes_ready during LOAD_MSG
        model_delay = 5; model_pt = P3;
        acc0 = wr_acc;
        write_job(K1, C1, 8, 1'b1, 5);
        check_eq("no_early_capture", dbg.rd_buf, '0);
        wait_aes(P3);
        drain_job(0);
        check_recycle(1'b0);
        check_eq("accepted_words", wr_acc, acc0 + 8);
        check_eq("key_hold", key, K1);
        check_eq("msg_en_hold", msg_en, C1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
